// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the 7-segment scan controller:
//   seg_state_t : scan FSM state encoding (IDLE/GUARD/DRIVE)
//   BCD_MAX     : largest legal BCD code, used for the error flag
//   cnt_width() : counter width helper (clog2, never below 1 bit)
// -----------------------------------------------------------------------------
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } seg_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Width needed to index n distinct values; a 1-bit minimum keeps
    // small configurations legal.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// -----------------------------------------------------------------------------
// seg_scan_timer
// Loadable down-counter shared by the guard and slot phases.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : load i_value into the counter this cycle
//   i_value    : phase length in cycles
//   o_tc       : high during the last cycle of the loaded phase
// The counter stops at zero and never wraps.
// -----------------------------------------------------------------------------
module seg_scan_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A phase loaded with N lasts N cycles: N, N-1, ..., 1.
    assign o_tc = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a NUM_DIGITS common-anode 7-segment
// display sharing one BCD decoder. Each digit gets GUARD_CYCLES all-off
// cycles followed by SLOT_CYCLES enabled cycles. Loaded digits are
// double-buffered (pending -> display) and only swapped at frame boundaries
// or while idle, so a frame never tears.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : run the scan; low returns to IDLE
//   load        : strobe capturing digits_in into the pending buffer
//   digits_in   : BCD digits, digit 0 in bits [3:0]
//   bcd_out     : BCD code for the decoder (registered)
//   digit_en_n  : active-low one-hot digit enables (registered)
//   frame_done  : one-cycle pulse after the last digit's slot
//   bcd_err     : bcd_out holds a code above 9
// Optional macro SEG_SCAN_LZB_EN: leading-zero blanking (digits above the
// highest nonzero digit stay dark; digit 0 is always shown).
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 1000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_done,
    output logic                    bcd_err
);

    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam int CNT_W = cnt_width(SLOT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LD  = CNT_W'(SLOT_CYCLES);

    seg_state_t                   r_state;
    logic [IDX_W-1:0]             r_idx;
    logic [NUM_DIGITS-1:0][3:0]   r_pend;
    logic [NUM_DIGITS-1:0][3:0]   r_disp;
    logic                         r_pend_valid;
    logic [3:0]                   r_bcd_out;
    logic [NUM_DIGITS-1:0]        r_digit_en_n;
    logic                         r_frame_done;

    seg_state_t                   w_state_nxt;
    logic [IDX_W-1:0]             w_idx_nxt;
    logic                         w_tmr_load;
    logic [CNT_W-1:0]             w_tmr_val;
    logic                         w_tmr_tc;
    logic                         w_frame_end;
    logic                         w_swap;
    logic [NUM_DIGITS-1:0][3:0]   w_digits;
    logic [NUM_DIGITS-1:0][3:0]   w_disp_nxt;
    logic [NUM_DIGITS-1:0][3:0]   w_pend_nxt;
    logic                         w_pend_valid_nxt;
    logic [NUM_DIGITS-1:0]        w_blank;
    logic [NUM_DIGITS-1:0]        w_en_n_nxt;

    assign w_digits = digits_in;

    seg_scan_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_tc    (w_tmr_tc)
    );

    // Next-state and timer control. A completed frame takes priority over a
    // dropped enable, so the last slot still reports frame_done.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tmr_load = 1'b1;
                w_idx_nxt  = '0;
                if (enable) begin
                    w_state_nxt = ST_GUARD;
                    w_tmr_val   = GUARD_LD;
                end
            end
            ST_GUARD: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_tmr_load  = 1'b1;
                end else if (w_tmr_tc) begin
                    w_state_nxt = ST_DRIVE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = SLOT_LD;
                end
            end
            ST_DRIVE: begin
                if (w_tmr_tc && (r_idx == LAST_IDX)) begin
                    w_frame_end = 1'b1;
                    w_idx_nxt   = '0;
                    w_tmr_load  = 1'b1;
                    if (enable) begin
                        w_state_nxt = ST_GUARD;
                        w_tmr_val   = GUARD_LD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_tmr_load  = 1'b1;
                end else if (w_tmr_tc) begin
                    w_state_nxt = ST_GUARD;
                    w_idx_nxt   = r_idx + 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = GUARD_LD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
                w_tmr_load  = 1'b1;
            end
        endcase
    end

    // Double buffer. A load on the swap edge bypasses pending; in IDLE the
    // pending value moves to display on the cycle after it was loaded.
    assign w_swap = w_frame_end || (r_state == ST_IDLE);

    always_comb begin
        w_disp_nxt       = r_disp;
        w_pend_nxt       = r_pend;
        w_pend_valid_nxt = r_pend_valid;
        if (w_frame_end && load) begin
            w_disp_nxt       = w_digits;
            w_pend_nxt       = w_digits;
            w_pend_valid_nxt = 1'b0;
        end else begin
            if (w_swap && r_pend_valid) begin
                w_disp_nxt       = r_pend;
                w_pend_valid_nxt = 1'b0;
            end
            if (load) begin
                w_pend_nxt       = w_digits;
                w_pend_valid_nxt = 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic w_upper_zero;

    // Walk down from the top digit; a digit is blank while it and every
    // digit above it are zero. Digit 0 is never blanked.
    always_comb begin
        w_blank      = '0;
        w_upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_upper_zero = w_upper_zero && (w_disp_nxt[i] == 4'd0);
            w_blank[i]   = w_upper_zero;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_comb begin
        w_en_n_nxt = '1;
        if ((w_state_nxt == ST_DRIVE) && !w_blank[w_idx_nxt]) begin
            w_en_n_nxt[w_idx_nxt] = 1'b0;
        end
    end

    // Outputs are registered from the next-state values so they change on
    // the same edge as the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_pend       <= '0;
            r_disp       <= '0;
            r_pend_valid <= 1'b0;
            r_bcd_out    <= 4'h0;
            r_digit_en_n <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_pend       <= w_pend_nxt;
            r_disp       <= w_disp_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_bcd_out    <= (w_state_nxt == ST_IDLE) ? 4'h0 : w_disp_nxt[w_idx_nxt];
            r_digit_en_n <= w_en_n_nxt;
            r_frame_done <= w_frame_end;
        end
    end

    assign bcd_out    = r_bcd_out;
    assign digit_en_n = r_digit_en_n;
    assign frame_done = r_frame_done;
    assign bcd_err    = (r_bcd_out > BCD_MAX);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle
// guard). A frame-position reference model predicts every output each cycle;
// a vector table and hand-written sequences cover the documented corners.
// Honors SEG_SCAN_LZB_EN in the model.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SC    = 8;
    localparam int GC    = 2;
    localparam int SLOT  = SC + GC;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en_n;
    logic        frame_done;
    logic        bcd_err;

    int errors = 0;
    int checks = 0;

    // Reference model state: running flag, cycles since scan start, buffers.
    bit          m_run;
    int          m_k;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pv;
    bit          m_fd;

    typedef struct {
        int         k;
        logic [3:0] bcd;
        logic [3:0] en_n;
        logic       fd;
    } vec_t;

    vec_t tbl[14];

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SC),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .bcd_out    (bcd_out),
        .digit_en_n (digit_en_n),
        .frame_done (frame_done),
        .bcd_err    (bcd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_run  = 1'b0;
        m_k    = 0;
        m_disp = '0;
        m_pend = '0;
        m_pv   = 1'b0;
        m_fd   = 1'b0;
    endtask

    // Digits s..3 all zero means digit s is a leading zero.
    function automatic bit m_blank(input int s);
`ifdef SEG_SCAN_LZB_EN
        if (s == 0) return 1'b0;
        return (m_disp >> (4 * s)) == 16'h0;
`else
        return (s < 0);
`endif
    endfunction

    // Expected {bcd_out, digit_en_n, frame_done, bcd_err} from frame position.
    function automatic logic [9:0] m_out();
        logic [3:0] b;
        logic [3:0] e;
        int p;
        int s;
        if (!m_run) return {4'h0, 4'hF, m_fd, 1'b0};
        p = m_k % FRAME;
        s = p / SLOT;
        b = m_disp[4*s +: 4];
        e = 4'hF;
        if ((p % SLOT) >= GC && !m_blank(s)) e[s] = 1'b0;
        return {b, e, m_fd, (b > 4'd9)};
    endfunction

    // One clock edge of the specified behaviour.
    task automatic m_edge(input bit en, input bit ld, input logic [15:0] din);
        bit fe;
        fe   = 1'b0;
        m_fd = 1'b0;
        if (m_run) begin
            fe = ((m_k + 1) % FRAME) == 0;
            if (fe) begin
                m_fd = 1'b1;
                if (ld) begin
                    m_disp = din;
                    m_pend = din;
                    m_pv   = 1'b0;
                end else if (m_pv) begin
                    m_disp = m_pend;
                    m_pv   = 1'b0;
                end
            end
            if (!fe && ld) begin
                m_pend = din;
                m_pv   = 1'b1;
            end
            if (en) m_k++;
            else    m_run = 1'b0;
        end else begin
            if (m_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end
            if (ld) begin
                m_pend = din;
                m_pv   = 1'b1;
            end
            if (en) begin
                m_run = 1'b1;
                m_k   = 0;
            end
        end
    endtask

    task automatic step(input bit en, input bit ld, input logic [15:0] din);
        enable    = en;
        load      = ld;
        digits_in = din;
        @(posedge clk);
        m_edge(en, ld, din);
        @(negedge clk);
        chk("model", {22'd0, bcd_out, digit_en_n, frame_done, bcd_err}, {22'd0, m_out()});
    endtask

    // Keep scanning until the model sits at frame position p (bounded).
    task automatic run_to(input int p);
        for (int i = 0; i < 2 * FRAME && (!m_run || (m_k % FRAME) != p); i++) begin
            step(1'b1, 1'b0, 16'h0);
        end
        chk("run_to_pos", m_k % FRAME, p);
    endtask

    initial begin
        logic [15:0] mask;
        bit          ren;
        bit          rld;

        tbl[0]  = '{0,  4'h4, 4'b1111, 1'b0};
        tbl[1]  = '{1,  4'h4, 4'b1111, 1'b0};
        tbl[2]  = '{2,  4'h4, 4'b1110, 1'b0};
        tbl[3]  = '{9,  4'h4, 4'b1110, 1'b0};
        tbl[4]  = '{10, 4'h3, 4'b1111, 1'b0};
        tbl[5]  = '{12, 4'h3, 4'b1101, 1'b0};
        tbl[6]  = '{19, 4'h3, 4'b1101, 1'b0};
        tbl[7]  = '{20, 4'h2, 4'b1111, 1'b0};
        tbl[8]  = '{22, 4'h2, 4'b1011, 1'b0};
        tbl[9]  = '{32, 4'h1, 4'b0111, 1'b0};
        tbl[10] = '{39, 4'h1, 4'b0111, 1'b0};
        tbl[11] = '{40, 4'h4, 4'b1111, 1'b1};
        tbl[12] = '{41, 4'h4, 4'b1111, 1'b0};
        tbl[13] = '{42, 4'h4, 4'b1110, 1'b0};

        // Reset and idle
        rst_n     = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0;
        m_reset();
        repeat (5) @(negedge clk);
        chk("reset_outputs", {bcd_out, digit_en_n, frame_done, bcd_err}, {4'h0, 4'hF, 1'b0, 1'b0});
        rst_n = 1'b1;
        repeat (100) step(1'b0, 1'b0, 16'h0);

        // Basic scan of 1234 against the vector table
        step(1'b0, 1'b1, 16'h1234);
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 14; i++) begin
            for (int n = 0; n < 2 * FRAME && m_k < tbl[i].k; n++) step(1'b1, 1'b0, 16'h0);
            chk($sformatf("scan_vec%0d", i), {bcd_out, digit_en_n, frame_done},
                {tbl[i].bcd, tbl[i].en_n, tbl[i].fd});
        end

        // Tear-free load in the middle of a frame
        run_to(14);
        step(1'b1, 1'b1, 16'h5678);
        run_to(32);
        chk("tear_old_digit3", bcd_out, 4'h1);
        run_to(2);
        chk("tear_new_digit0", {bcd_out, digit_en_n}, {4'h8, 4'b1110});
        run_to(12);
        chk("tear_new_digit1", {bcd_out, digit_en_n}, {4'h7, 4'b1101});

        // Load coincident with the frame swap
        run_to(39);
        step(1'b1, 1'b1, 16'h9999);
        chk("swap_load_fd", {bcd_out, frame_done}, {4'h9, 1'b1});
        chk("swap_load_pv", dut.r_pend_valid, 1'b0);
        run_to(2);
        chk("swap_load_shown", {bcd_out, digit_en_n}, {4'h9, 4'b1110});

        // Enable dropped in DRIVE of digit 2, then restart at digit 0
        run_to(25);
        chk("pre_disable", digit_en_n, 4'b1011);
        step(1'b0, 1'b0, 16'h0);
        chk("disable_off", {bcd_out, digit_en_n, frame_done}, {4'h0, 4'hF, 1'b0});
        repeat (3) step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("reenable_guard0", {bcd_out, digit_en_n}, {4'h9, 4'hF});
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("reenable_drive0", digit_en_n, 4'b1110);

        // Asynchronous reset mid-DRIVE drops a pending load
        run_to(22);
        step(1'b1, 1'b1, 16'h4321);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {bcd_out, digit_en_n, frame_done, bcd_err}, {4'h0, 4'hF, 1'b0, 1'b0});
        m_reset();
        enable = 1'b0;
        load   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        run_to(2);
        chk("pending_lost", {bcd_out, digit_en_n}, {4'h0, 4'b1110});
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);

        // Illegal BCD code on digit 1
        step(1'b0, 1'b1, 16'h00A0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        run_to(2);
        chk("err_digit0", bcd_err, 1'b0);
        run_to(12);
        chk("err_digit1", {bcd_out, bcd_err}, {4'hA, 1'b1});
        run_to(22);
        chk("err_digit2", bcd_err, 1'b0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);

        // Leading zeros: 0007
        step(1'b0, 1'b1, 16'h0007);
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        run_to(2);
        chk("lzb_digit0", {bcd_out, digit_en_n}, {4'h7, 4'b1110});
        run_to(12);
`ifdef SEG_SCAN_LZB_EN
        chk("lzb_digit1", digit_en_n, 4'b1111);
`else
        chk("lzb_digit1", digit_en_n, 4'b1101);
`endif
        run_to(32);
`ifdef SEG_SCAN_LZB_EN
        chk("lzb_digit3", digit_en_n, 4'b1111);
`else
        chk("lzb_digit3", digit_en_n, 4'b0111);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       mask = 16'h000F;
                1:       mask = 16'h00FF;
                2:       mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            ren = ($urandom_range(0, 39) != 0);
            rld = ($urandom_range(0, 24) == 0);
            step(ren, rld, 16'($urandom) & mask);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
